// File: rtl/wb_regfile_pkg.sv
// Shared widths, load-format encodings and extension helpers for the write-back stage.
// Latency: none (types, constants and pure functions only).
// Backpressure: none; nothing in this package carries flow control.
package wb_regfile_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int REG_SIZE   = 5;
    localparam int NUM_REGS   = 1 << REG_SIZE;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [REG_SIZE-1:0]   reg_addr_t;

    localparam word_t ZEROWORD = '0;

    // Load formats shared with decode and MEM control; 101-111 behave as LW.
    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

    function automatic word_t ext_byte(input logic [7:0] b, input logic sgn);
        return {{(WORD_WIDTH-8){sgn & b[7]}}, b};
    endfunction

    function automatic word_t ext_half(input logic [15:0] h, input logic sgn);
        return {{(WORD_WIDTH-16){sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back bundle, decode read ports and monitor outputs of the register file.
// Latency: wires only; register file reads are combinational.
// Backpressure: none; the pipeline presents one bundle every cycle.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic        Regfile_weW;
    logic        memToRegW;
    logic [2:0]  loadTypeW;
    word_t       aluOutW;
    word_t       readDataW;
    reg_addr_t   writeRegAddrW;
    reg_addr_t   rsAddrD;
    reg_addr_t   rtAddrD;
    word_t       rsDataD;
    word_t       rtDataD;
    word_t       resultW;
    word_t       wbCount;

    // Pipeline side: drives the MEM/WB bundle and decode addresses.
    modport master (
        output Regfile_weW, memToRegW, loadTypeW, aluOutW, readDataW,
               writeRegAddrW, rsAddrD, rtAddrD,
        input  rsDataD, rtDataD, resultW, wbCount
    );

    // Register file side.
    modport slave (
        input  Regfile_weW, memToRegW, loadTypeW, aluOutW, readDataW,
               writeRegAddrW, rsAddrD, rtAddrD,
        output rsDataD, rtDataD, resultW, wbCount
    );

endinterface

// File: rtl/wb_regfile_load_ext.sv
// Selects the byte/half lane of a loaded word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
module wb_regfile_load_ext
    import wb_regfile_pkg::*;
(
    input  word_t       rdata,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  load_type,
    output word_t       load_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane pick; halfword ignores byte_off[0] so odd halves never trap.
    always_comb begin
        byte_sel = rdata[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (load_type)
            LT_LB:   load_val = ext_byte(byte_sel, 1'b1);
            LT_LBU:  load_val = ext_byte(byte_sel, 1'b0);
            LT_LH:   load_val = ext_half(half_sel, 1'b1);
            LT_LHU:  load_val = ext_half(half_sel, 1'b0);
            default: load_val = rdata;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back mux, 32x32 register file with write-through read ports, commit counter.
// Latency: reads combinational, writes land at the next clk edge (bypassed before that).
// Backpressure: none; a write-back is accepted every cycle it is presented.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   wb
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];
    word_t wb_count_q;
    word_t wb_count_d;
    word_t load_val;
    word_t result;
    logic  commit;

    wb_regfile_load_ext u_load_ext (
        .rdata     (wb.readDataW),
        .byte_off  (wb.aluOutW[1:0]),
        .load_type (wb.loadTypeW),
        .load_val  (load_val)
    );

    // Result select; r0 writes and writes under reset never commit.
    always_comb begin
        result = wb.memToRegW ? load_val : wb.aluOutW;
        commit = wb.Regfile_weW && (wb.writeRegAddrW != '0) && !rst;
    end

    // Read ports: zero under reset or for r0, otherwise bypass the in-flight write.
    always_comb begin
        wb.resultW = result;
        wb.wbCount = wb_count_q;
        if (rst || wb.rsAddrD == '0)
            wb.rsDataD = ZEROWORD;
        else if (commit && wb.writeRegAddrW == wb.rsAddrD)
            wb.rsDataD = result;
        else
            wb.rsDataD = regs_q[wb.rsAddrD];
        if (rst || wb.rtAddrD == '0)
            wb.rtDataD = ZEROWORD;
        else if (commit && wb.writeRegAddrW == wb.rtAddrD)
            wb.rtDataD = result;
        else
            wb.rtDataD = regs_q[wb.rtAddrD];
    end

    // Next array and counter state: reset clears everything, a commit updates one entry.
    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_d[i] = ZEROWORD;
            wb_count_d = ZEROWORD;
        end else if (commit) begin
            regs_d[wb.writeRegAddrW] = result;
            wb_count_d               = wb_count_q + 32'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        regs_q     <= regs_d;
        wb_count_q <= wb_count_d;
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic clk;
    logic rst;
    int   err_cnt;
    int   chk_cnt;

    logic [31:0] mregs [32];
    logic [31:0] mcount;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference load/write-back value from the architectural rules.
    function automatic logic [31:0] ref_result(input logic m2r, input logic [2:0] lt,
                                               input logic [31:0] alu, input logic [31:0] rd);
        int unsigned k;
        logic [31:0] b, h;
        k = alu % 4;
        b = (rd >> (8 * k)) % 256;
        h = ((alu % 4) >= 2) ? (rd >> 16) : (rd % 65536);
        if (!m2r) return alu;
        case (lt)
            3'd1:    return (b >= 128) ? b - 32'd256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    task automatic drive(input logic we, input logic m2r, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] wa, input logic [4:0] ra, input logic [4:0] rb);
        bus.Regfile_weW   = we;
        bus.memToRegW     = m2r;
        bus.loadTypeW     = lt;
        bus.aluOutW       = alu;
        bus.readDataW     = rd;
        bus.writeRegAddrW = wa;
        bus.rsAddrD       = ra;
        bus.rtAddrD       = rb;
    endtask

    // Check outputs mid-cycle against the model, then advance one edge.
    task automatic cycle(input string tag);
        logic [31:0] res, ea, eb;
        bit cm;
        #1;
        res = ref_result(bus.memToRegW, bus.loadTypeW, bus.aluOutW, bus.readDataW);
        cm  = bus.Regfile_weW && bus.writeRegAddrW != 0 && !rst;
        ea  = (rst || bus.rsAddrD == 0) ? 32'd0 :
              (cm && bus.writeRegAddrW == bus.rsAddrD) ? res : mregs[bus.rsAddrD];
        eb  = (rst || bus.rtAddrD == 0) ? 32'd0 :
              (cm && bus.writeRegAddrW == bus.rtAddrD) ? res : mregs[bus.rtAddrD];
        chk({tag, ".res"}, bus.resultW, res);
        chk({tag, ".rs"},  bus.rsDataD, ea);
        chk({tag, ".rt"},  bus.rtDataD, eb);
        chk({tag, ".cnt"}, bus.wbCount, mcount);
        @(posedge clk);
        if (rst) begin
            foreach (mregs[i]) mregs[i] = 32'd0;
            mcount = 32'd0;
        end else if (cm) begin
            mregs[bus.writeRegAddrW] = res;
            mcount = mcount + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  lts [6];
        logic [31:0] alus [6];
        logic [31:0] exps [6];
        err_cnt = 0;
        chk_cnt = 0;
        foreach (mregs[i]) mregs[i] = 32'd0;
        mcount = 32'd0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cycle("init");
        rst = 1'b0;

        // Reset clears a preloaded register and drops a write issued under reset.
        drive(1, 0, 0, 32'h1234_5678, 0, 5, 5, 0);
        cycle("pre5");
        rst = 1'b1;
        drive(1, 0, 0, 32'hCAFE_0001, 0, 6, 5, 6);
        cycle("rstw");
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 5, 6);
        #1;
        chk("rst_r5", bus.rsDataD, 32'd0);
        chk("rst_r6", bus.rtDataD, 32'd0);
        chk("rst_cnt", bus.wbCount, 32'd0);
        cycle("postrst");

        // ALU write-back with same-cycle bypass, then read from the array.
        drive(1, 0, 0, 32'hDEAD_BEEF, 0, 7, 7, 0);
        #1 chk("byp_r7", bus.rsDataD, 32'hDEAD_BEEF);
        cycle("alu7");
        drive(0, 0, 0, 32'h0, 0, 7, 7, 0);
        #1;
        chk("arr_r7", bus.rsDataD, 32'hDEAD_BEEF);
        chk("cnt1", bus.wbCount, 32'd1);
        cycle("rd7");

        // Load extraction on 0x80FF_7F01.
        lts  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        alus = '{32'h100, 32'h102, 32'h103, 32'h102, 32'h100, 32'h103};
        exps = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0080,
                 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, lts[i], alus[i], 32'h80FF_7F01, 5'(10 + i), 5'(10 + i), 0);
            #1 chk($sformatf("ld%0d", i), bus.resultW, exps[i]);
            cycle($sformatf("ldc%0d", i));
        end

        // r0 stays zero and an r0 write does not count.
        drive(1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        #1 chk("r0_byp", bus.rsDataD, 32'd0);
        cycle("r0w");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r0_arr", bus.rtDataD, 32'd0);
        chk("r0_cnt", bus.wbCount, 32'd7);
        cycle("r0r");

        // Both ports on one register, then a disabled write.
        drive(1, 0, 0, 32'h55, 0, 9, 9, 9);
        cycle("dp55");
        drive(0, 0, 0, 32'hAA, 0, 9, 9, 9);
        #1;
        chk("dp_rs", bus.rsDataD, 32'h55);
        chk("dp_rt", bus.rtDataD, 32'h55);
        cycle("dpaa");

        // Counter wrap.
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1 release dut.wb_count_q;
        mcount = 32'hFFFF_FFFF;
        drive(1, 0, 0, 32'h3, 0, 3, 0, 0);
        cycle("wrap");
        #1 chk("wrap_cnt", bus.wbCount, 32'd0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            cycle($sformatf("rnd%0d", n));
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
